unpadding_stream: RTL

//   Receive side of the block-padding scheme. The pad side places payload in the low bits,

---
 rtl/unpadding_stream_pkg.sv | 32 +++
 rtl/unpadding_stream_if.sv | 28 ++
 rtl/unpadding_stream_chunk_msb_find.sv | 17 +
 rtl/unpadding_stream.sv | 102 ++++++++++
 4 files changed

// File: rtl/unpadding_stream_pkg.sv
// Shared types and helpers for the block-unpadding receive path.
// Holds the FSM state encoding and the chunk priority-encoder function.
package unpad_pkg;

  typedef enum logic [1:0] {IDLE, SCAN, EMIT} state_t;

  localparam int IWIDTH_DEF = 64;
  localparam int LENW       = $clog2(IWIDTH_DEF + 1);

  // Widest chunk the shared encoder handles; narrower chunks are zero-extended.
  localparam int MAXCHUNK = 32;
  localparam int MIDXW    = $clog2(MAXCHUNK);

  typedef struct packed {
    logic             found;
    logic [MIDXW-1:0] index;
  } msb_t;

  function automatic msb_t msb_index(input logic [MAXCHUNK-1:0] chunk);
    msb_t r;
    r.found = 1'b0;
    r.index = '0;
    for (int i = 0; i < MAXCHUNK; i++) begin
      if (chunk[i]) begin
        r.found = 1'b1;
        r.index = MIDXW'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/unpadding_stream_if.sv
// Padded-block input stream and unpadded-result output stream.
// slave is the unpadder's view, master is the source/consumer view.
interface unpad_if
  import unpad_pkg::*;
#(
  parameter int IWIDTH = 64,
  parameter int BWIDTH = 32,
  parameter int LW     = LENW
);
  logic              in_valid;
  logic              in_ready;
  logic [IWIDTH-1:0] in_block;
  logic              out_valid;
  logic              out_ready;
  logic [BWIDTH-1:0] out_block;
  logic [LW-1:0]     out_len;
  logic              out_err;

  modport slave (
    input  in_valid, in_block, out_ready,
    output in_ready, out_valid, out_block, out_len, out_err
  );

  modport master (
    output in_valid, in_block, out_ready,
    input  in_ready, out_valid, out_block, out_len, out_err
  );
endinterface

// File: rtl/unpadding_stream_chunk_msb_find.sv
// Combinational priority encoder: reports whether any bit of a chunk is set
// and the index of the highest set bit.
module chunk_msb_find
  import unpad_pkg::*;
#(
  parameter  int CHUNK = 8,
  localparam int IDXW  = (CHUNK > 1) ? $clog2(CHUNK) : 1
) (
  input  logic [CHUNK-1:0] chunk,
  output logic             any_set,
  output logic [IDXW-1:0]  msb_idx
);
  logic [MIDXW-1:0] idx_full;

  assign {any_set, idx_full} = msb_index(MAXCHUNK'(chunk));
  assign msb_idx             = IDXW'(idx_full);
endmodule

// File: rtl/unpadding_stream.sv
// Unpadding receiver: scans a latched padded block MSB-first, one chunk per
// cycle, for the '1' marker, then presents the payload, its length and an error flag.
module unpadding_stream
  import unpad_pkg::*;
#(
  parameter int IWIDTH = 64,
  parameter int BWIDTH = 32,
  parameter int CHUNK  = 8,
  parameter int CNTW   = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  unpad_if.slave          bus,
  output logic [CNTW-1:0] err_count
);
  localparam int NCHUNK = IWIDTH / CHUNK;
  localparam int LW     = $clog2(IWIDTH + 1);
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int IDXW   = (CHUNK > 1) ? $clog2(CHUNK) : 1;

  state_t            state, state_nxt;
  logic [IWIDTH-1:0] blk_p0;
  logic [CW-1:0]     c_p0;
  logic [LW-1:0]     m_p1;
  logic              nomark_p1;
  logic [CHUNK-1:0]  chunk;
  logic              any_set;
  logic [IDXW-1:0]   msb_idx;
  logic [BWIDTH-1:0] pay;
  logic              gap;
  logic              hs_out;

  assign chunk        = blk_p0[c_p0*CHUNK +: CHUNK];
  assign bus.in_ready = (state == IDLE);
  assign hs_out       = bus.out_valid && bus.out_ready;

  chunk_msb_find #(.CHUNK(CHUNK)) u_find (
    .chunk   (chunk),
    .any_set (any_set),
    .msb_idx (msb_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = SCAN;
      SCAN:    if (any_set || c_p0 == '0) state_nxt = EMIT;
      EMIT:    if (hs_out) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // p0: block latch and chunk walk; p1: marker position once the scan resolves
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.in_valid) begin
      blk_p0 <= bus.in_block;
      c_p0   <= CW'(NCHUNK - 1);
    end else if (state == SCAN) begin
      if (any_set) begin
        m_p1      <= LW'(c_p0) * LW'(CHUNK) + LW'(msb_idx);
        nomark_p1 <= 1'b0;
      end else if (c_p0 == '0) begin
        m_p1      <= '0;
        nomark_p1 <= 1'b1;
      end else begin
        c_p0 <= c_p0 - CW'(1);
      end
    end
  end

  // Payload keeps only bits below the marker; any set bit between BWIDTH and the marker is an error.
  always_comb begin
    pay = '0;
    gap = 1'b0;
    for (int i = 0; i < BWIDTH; i++) pay[i] = blk_p0[i] & (LW'(i) < m_p1);
    for (int i = BWIDTH; i < IWIDTH; i++) gap = gap | (blk_p0[i] & (LW'(i) < m_p1));
  end

  // p2: result registers, loaded on the first EMIT cycle and held until handoff
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_block <= '0;
      bus.out_len   <= '0;
      bus.out_err   <= 1'b0;
      err_count     <= '0;
    end else if (state == EMIT && !bus.out_valid) begin
      bus.out_valid <= 1'b1;
      bus.out_block <= pay;
      bus.out_len   <= m_p1;
      bus.out_err   <= nomark_p1 | gap;
    end else if (hs_out) begin
      bus.out_valid <= 1'b0;
      if (bus.out_err && err_count != '1) err_count <= err_count + CNTW'(1);
    end
  end
endmodule
